// File: rtl/uart_rx_fifo_top.sv
// 16x-oversampled 8N1 UART receiver feeding a show-ahead FIFO.
// Define UART_RX_PARITY_EN to expect an even parity bit before stop.
module uart_rx_fifo_top #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iTick16x,
  input  logic                    iRx,
  input  logic                    iPopValid,
  output logic [P_DATA_WIDTH-1:0] oPopData,
  output logic                    oEmpty,
  output logic                    oFull,
  output logic                    oBusy,
  output logic                    oFrameErr,
  output logic                    oOverrun,
  output logic                    oParityErr
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(P_DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t state, stateNxt;

  logic                    rxMeta, rxS;
  logic [3:0]              tickCnt;
  logic [BW-1:0]           bitCnt;
  logic [P_DATA_WIDTH-1:0] shiftReg;
  logic                    sampleTick, lastBit;
  logic                    pushReq, frameErrNxt;
  logic                    doPush, doPop;

  logic [P_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
  logic [AW-1:0]           rdPtr, wrPtr;
  logic [CW-1:0]           count;

`ifdef UART_RX_PARITY_EN
  logic parErr, parityErrNxt;
`endif

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= iRx;
      rxS    <= rxMeta;
    end
  end

  assign sampleTick = iTick16x && (tickCnt == 4'hF);
  assign lastBit    = bitCnt == BW'(P_DATA_WIDTH - 1);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:
        if (iTick16x && !rxS) stateNxt = START;
      START:
        if (iTick16x && tickCnt == 4'd7)
          stateNxt = rxS ? IDLE : DATA;
      DATA:
        if (sampleTick && lastBit)
`ifdef UART_RX_PARITY_EN
          stateNxt = PARITY;
      PARITY:
        if (sampleTick) stateNxt = STOP;
`else
          stateNxt = STOP;
`endif
      STOP:
        if (sampleTick) stateNxt = rxS ? IDLE : BREAK;
      BREAK:
        if (rxS) stateNxt = IDLE;
      default:
        stateNxt = IDLE;
    endcase
  end

  always_comb begin
    pushReq     = 1'b0;
    frameErrNxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    parityErrNxt = 1'b0;
`endif
    if (state == STOP && sampleTick) begin
`ifdef UART_RX_PARITY_EN
      pushReq      = rxS & ~parErr;
      parityErrNxt = rxS & parErr;
`else
      pushReq      = rxS;
`endif
      frameErrNxt  = ~rxS;
    end
  end

  assign oBusy = state != IDLE;

  // tickCnt is re-zeroed at the start midpoint so data samples land mid-bit
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      tickCnt  <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
`ifdef UART_RX_PARITY_EN
      parErr   <= 1'b0;
`endif
    end else if (iTick16x) begin
      if (state == IDLE) begin
        tickCnt <= '0;
        bitCnt  <= '0;
      end else if (state == START && tickCnt == 4'd7) begin
        tickCnt <= '0;
      end else begin
        tickCnt <= tickCnt + 4'd1;
      end
      if (state == DATA && tickCnt == 4'hF) begin
        shiftReg <= {rxS, shiftReg[P_DATA_WIDTH-1:1]};
        bitCnt   <= bitCnt + BW'(1);
      end
`ifdef UART_RX_PARITY_EN
      if (state == PARITY && tickCnt == 4'hF)
        parErr <= rxS ^ (^shiftReg);
`endif
    end
  end

  assign oEmpty   = count == '0;
  assign oFull    = count == CW'(P_FIFO_DEPTH);
  assign oPopData = mem[rdPtr];
  assign doPop    = iPopValid && !oEmpty;
  assign doPush   = pushReq && (!oFull || doPop);

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oFrameErr <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      oFrameErr <= frameErrNxt;
      oOverrun  <= pushReq && oFull && !doPop;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) oParityErr <= 1'b0;
    else       oParityErr <= parityErrNxt;
  end
`else
  assign oParityErr = 1'b0;
`endif

  // on a full FIFO the write slot equals the slot being popped
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < P_FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= shiftReg;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) rdPtr <= rdPtr + AW'(1);
      unique case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_top.sv
// Directed bench for uart_rx_fifo_top: frames, glitch, framing error,
// overrun, full push+pop, mid-frame reset and optional parity.
module tb_uart_rx_fifo_top;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int BITCLK  = 64;
  localparam int STOPTK  = PAR ? 168 : 152;
  localparam int POPEDGE = 4 + 4 * STOPTK - 1;

  logic       iClk = 1'b0;
  logic       iRst = 1'b0;
  logic       iTick16x;
  logic       iRx = 1'b1;
  logic       iPopValid = 1'b0;
  logic [7:0] oPopData;
  logic       oEmpty, oFull, oBusy;
  logic       oFrameErr, oOverrun, oParityErr;

  logic [1:0] tickDiv = '0;
  int nChk = 0;
  int nFail = 0;
  int feCnt = 0;
  int ovCnt = 0;
  int peCnt = 0;
  int fe0, ov0, pe0;

  uart_rx_fifo_top dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iTick16x   (iTick16x),
    .iRx        (iRx),
    .iPopValid  (iPopValid),
    .oPopData   (oPopData),
    .oEmpty     (oEmpty),
    .oFull      (oFull),
    .oBusy      (oBusy),
    .oFrameErr  (oFrameErr),
    .oOverrun   (oOverrun),
    .oParityErr (oParityErr)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) tickDiv <= tickDiv + 2'd1;
  assign iTick16x = tickDiv == 2'd3;

  always @(posedge iClk) begin
    if (oFrameErr)  feCnt <= feCnt + 1;
    if (oOverrun)   ovCnt <= ovCnt + 1;
    if (oParityErr) peCnt <= peCnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nChk++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  // returns 1 time unit after a clock edge that carried a tick
  task automatic alignTick();
    clk(1);
    while (tickDiv != 2'd3) clk(1);
    clk(1);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic parFlip,
                           input logic stopVal, input int stopLen);
    iRx = 1'b0;
    clk(BITCLK);
    for (int i = 0; i < 8; i++) begin
      iRx = d[i];
      clk(BITCLK);
    end
    if (PAR) begin
      iRx = (^d) ^ parFlip;
      clk(BITCLK);
    end
    iRx = stopVal;
    clk(BITCLK * stopLen);
  endtask

  task automatic sendByte(input logic [7:0] d);
    alignTick();
    sendFrame(d, 1'b0, 1'b1, 1);
    clk(4);
  endtask

  task automatic popCheck(input string tag, input logic [7:0] exp);
    check({tag, "_nonempty"}, oEmpty, 1'b0);
    check({tag, "_data"}, oPopData, exp);
    iPopValid = 1'b1;
    clk(1);
    iPopValid = 1'b0;
  endtask

  initial begin
    clk(3);
    check("rst_empty", oEmpty, 1'b1);
    check("rst_full", oFull, 1'b0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_data", oPopData, 8'h00);
    check("rst_errs", {oFrameErr, oOverrun, oParityErr}, 3'b000);
    iRst = 1'b1;
    clk(4);

    sendByte(8'hA5);
    check("a5_empty", oEmpty, 1'b0);
    check("a5_busy", oBusy, 1'b0);
    popCheck("a5", 8'hA5);
    check("a5_popempty", oEmpty, 1'b1);
    check("a5_noerr", feCnt + ovCnt + peCnt, 0);

    alignTick();
    iRx = 1'b0;
    clk(13);
    check("glitch_busy", oBusy, 1'b1);
    clk(2);
    iRx = 1'b1;
    clk(64);
    check("glitch_idle", oBusy, 1'b0);
    check("glitch_nopush", oEmpty, 1'b1);
    check("glitch_noerr", feCnt + ovCnt + peCnt, 0);

    sendByte(8'h5A);
    check("mid_pre", oPopData, 8'h5A);
    alignTick();
    iRx = 1'b0;
    clk(100);
    check("mid_busy", oBusy, 1'b1);
    iRst = 1'b0;
    iRx  = 1'b1;
    #1;
    check("mid_rstbusy", oBusy, 1'b0);
    check("mid_rstempty", oEmpty, 1'b1);
    check("mid_rstdata", oPopData, 8'h00);
    clk(3);
    iRst = 1'b1;
    clk(BITCLK * 12);
    check("mid_after", {oBusy, oEmpty}, 2'b01);

    fe0 = feCnt;
    alignTick();
    sendFrame(8'h3C, 1'b0, 1'b0, 3);
    check("fe_pulse", feCnt - fe0, 1);
    check("fe_busy", oBusy, 1'b1);
    check("fe_nopush", oEmpty, 1'b1);
    iRx = 1'b1;
    clk(6);
    check("fe_release", oBusy, 1'b0);

    ov0 = ovCnt;
    for (int i = 0; i < 17; i++) begin
      sendByte(8'(i));
      if (i == 14) check("fill_notfull", oFull, 1'b0);
      if (i == 15) check("fill_full", oFull, 1'b1);
      if (i == 15) check("fill_noov", ovCnt - ov0, 0);
    end
    check("ov_pulse", ovCnt - ov0, 1);
    check("ov_full", oFull, 1'b1);
    check("ov_head", oPopData, 8'h00);

    ov0 = ovCnt;
    alignTick();
    fork
      sendFrame(8'h55, 1'b0, 1'b1, 1);
      begin
        repeat (POPEDGE) @(posedge iClk);
        #1 iPopValid = 1'b1;
        @(posedge iClk);
        #1 iPopValid = 1'b0;
      end
    join
    clk(4);
    check("pp_full", oFull, 1'b1);
    check("pp_noov", ovCnt - ov0, 0);

    for (int i = 1; i < 16; i++) popCheck("drain", 8'(i));
    popCheck("drain_last", 8'h55);
    check("drain_empty", oEmpty, 1'b1);
    check("drain_notfull", oFull, 1'b0);

`ifdef UART_RX_PARITY_EN
    pe0 = peCnt;
    alignTick();
    sendFrame(8'h07, 1'b1, 1'b1, 1);
    clk(4);
    check("par_bad_pulse", peCnt - pe0, 1);
    check("par_bad_nopush", oEmpty, 1'b1);
    alignTick();
    sendFrame(8'h07, 1'b0, 1'b1, 1);
    clk(4);
    check("par_good_nopulse", peCnt - pe0, 1);
    popCheck("par_good", 8'h07);
`endif
    pe0 = PAR ? 1 : 0;
    check("par_total", peCnt, pe0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
